// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with valid/ready output and framing/overrun flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_os #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS = 8
) (
   input  logic                 inp_clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 busy,
   output logic                 frame_err,
   output logic                 overrun
`ifdef UART_RX_PARITY_EN
   ,output logic                parity_err
`endif
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IL = IW'(DATA_BITS - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
   state_t state, state_n;
   logic [1:0] sync;
   logic rx_s;
   logic [CW-1:0] cnt, cnt_n;
   logic [IW-1:0] idx, idx_n;
   logic [DATA_BITS-1:0] sh, sh_n;
   logic done, bad;
`ifdef UART_RX_PARITY_EN
   logic par, par_n;
`endif
   assign rx_s = sync[1];
   assign busy = state != IDLE;
   always_ff @(posedge inp_clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      cnt_n = cnt + 1'b1;
      idx_n = idx;
      sh_n = sh;
      done = 1'b0;
      bad = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_n = par;
`endif
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_s) state_n = START;
         end
         START: if (cnt == HALF) begin
            cnt_n = '0;
            idx_n = '0;
            state_n = rx_s ? IDLE : DATA;
         end
         DATA: if (cnt == LAST) begin
            cnt_n = '0;
            sh_n = {rx_s, sh[DATA_BITS-1:1]};
            idx_n = idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (idx == IL) state_n = PARITY;
`else
            if (idx == IL) state_n = STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (cnt == LAST) begin
            cnt_n = '0;
            par_n = rx_s;
            state_n = STOP;
         end
`endif
         STOP: if (cnt == LAST) begin
            cnt_n = '0;
            done = rx_s;
            bad = !rx_s;
            state_n = rx_s ? IDLE : WAIT_IDLE;
         end
         WAIT_IDLE: begin
            cnt_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge inp_clk or posedge rst)
      if (rst) begin
         sync <= 2'b11;
         cnt <= '0;
         idx <= '0;
         sh <= '0;
         rx_data <= '0;
         rx_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         sync <= {sync[0], rx};
         cnt <= cnt_n;
         idx <= idx_n;
         sh <= sh_n;
         frame_err <= bad;
         overrun <= done & rx_valid & ~rx_ready;
`ifdef UART_RX_PARITY_EN
         par <= par_n;
         parity_err <= done & (^{sh, par});
`endif
         // a completing word wins over a same-edge handshake
         if (done) begin
            rx_data <= sh;
            rx_valid <= 1'b1;
         end else if (rx_valid & rx_ready) rx_valid <= 1'b0;
      end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed frames against a frame-level timing model of the receiver.
module tb_uart_rx_os;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int N = 8192;
   logic inp_clk = 1'b0, rst = 1'b1, rx = 1'b1, rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic rx_valid, busy, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
   logic parity_err;
`endif
   uart_rx_os dut (
      .inp_clk(inp_clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .busy(busy), .frame_err(frame_err), .overrun(overrun)
`ifdef UART_RX_PARITY_EN
      , .parity_err(parity_err)
`endif
   );
   always #5 inp_clk = ~inp_clk;
   int c = 0, pass = 0, total = 0, bs = 0, be = 0;
   int ev_kind[N];
   logic [7:0] ev_data[N];
   logic ev_perr[N];
   logic h_valid[N], h_busy[N], h_ferr[N], h_ovr[N], h_perr[N];
   logic [7:0] h_data[N];
   logic mv = 1'b0, mo = 1'b0, mf = 1'b0, mp = 1'b0, rdy;
   logic [7:0] md = 8'h00;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a === e) pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, c);
   endtask
   initial forever begin
      @(posedge inp_clk);
      c++;
      rdy = rx_ready;
      #1;
      if (rst) begin
         mv = 0; md = 0; mo = 0; mf = 0; mp = 0;
      end else begin
         mo = 0; mf = 0; mp = 0;
         if (ev_kind[c] == 1) begin
            mo = mv & ~rdy;
            mv = 1;
            md = ev_data[c];
            mp = ev_perr[c];
         end else if (mv & rdy) mv = 0;
         if (ev_kind[c] == 2) mf = 1;
      end
      chk("rx_valid", rx_valid, mv);
      chk("rx_data", rx_data, md);
      chk("busy", busy, !rst && c >= bs && c < be);
      chk("frame_err", frame_err, mf);
      chk("overrun", overrun, mo);
`ifdef UART_RX_PARITY_EN
      chk("parity_err", parity_err, mp);
      h_perr[c] = parity_err;
`else
      h_perr[c] = mp;
`endif
      h_valid[c] = rx_valid; h_busy[c] = busy; h_ferr[c] = frame_err;
      h_ovr[c] = overrun; h_data[c] = rx_data;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: cycle %0d reached, finish required", c);
      $fatal(1);
   end
   task automatic hold(input int n);
      repeat (n) @(posedge inp_clk);
      #2;
   endtask
   // frame starting now; schedules the model's expectations, returns edge k and stop-sample edge t
   task automatic send(input logic [7:0] d, input logic pb, input int low, output int k, output int t);
      k = c + 1;
      t = k + 154 + 16 * PB;
      rx = 1'b0;
      bs = k + 2;
      if (low == 0) begin
         be = t; ev_kind[t] = 1; ev_data[t] = d; ev_perr[t] = (PB == 1) && (pb != ^d);
      end else begin
         be = k + 16 * (9 + PB + low) + 2; ev_kind[t] = 2;
      end
      hold(16);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         hold(16);
      end
      if (PB == 1) begin
         rx = pb;
         hold(16);
      end
      if (low > 0) begin
         rx = 1'b0;
         hold(16 * low);
      end
      rx = 1'b1;
      hold(16);
   endtask
   initial begin
      int k, t, e;
      hold(3);
      chk("rst_valid", rx_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", rx_data, 0);
      rst = 1'b0;
      hold(5);
      send(8'hA5, ^8'hA5, 0, k, t);
      chk("a5_before", h_valid[t-1], 0);
      chk("a5_valid", h_valid[t], 1);
      chk("a5_data", h_data[t], 8'hA5);
      chk("a5_one_cycle", h_valid[t+1], 0);
      chk("a5_no_ferr", h_ferr[t], 0);
      chk("a5_latency", t - k, 154 + 16 * PB);
      k = c + 1; rx = 1'b0; bs = k + 2; be = k + 10;
      hold(5);
      rx = 1'b1;
      hold(30);
      chk("gl_busy_pre", h_busy[k+1], 0);
      chk("gl_busy_on", h_busy[k+9], 1);
      chk("gl_busy_off", h_busy[k+10], 0);
      send(8'h3C, ^8'h3C, 3, k, t);
      chk("fe_pulse", h_ferr[t], 1);
      chk("fe_once", h_ferr[t+1], 0);
      chk("fe_no_valid", h_valid[t], 0);
      send(8'h81, ^8'h81, 0, k, t);
      chk("x81_data", h_data[t], 8'h81);
      rx_ready = 1'b0;
      send(8'h11, ^8'h11, 0, k, t);
      chk("ov_first", h_data[t], 8'h11);
      send(8'h22, ^8'h22, 0, k, t);
      chk("ov_pulse", h_ovr[t], 1);
      chk("ov_data", h_data[t], 8'h22);
      chk("ov_once", h_ovr[t+1], 0);
      hold(10);
      rx_ready = 1'b1;
      e = c;
      hold(3);
      chk("ov_held", h_valid[e], 1);
      chk("ov_clear", h_valid[e+1], 0);
      k = c + 1; rx = 1'b0; bs = k + 2; be = 1 << 30;
      hold(16);
      for (int i = 0; i < 4; i++) begin
         rx = 1'b1;
         hold(16);
      end
      hold(8);
      rst = 1'b1; be = 0; rx = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", rx_valid, 0);
      chk("mid_rst_data", rx_data, 0);
      hold(3);
      rst = 1'b0;
      hold(20);
      send(8'h5A, ^8'h5A, 0, k, t);
      chk("x5a_data", h_data[t], 8'h5A);
      chk("x5a_valid", h_valid[t], 1);
`ifdef UART_RX_PARITY_EN
      send(8'h07, 1'b0, 0, k, t);
      chk("par_bad", h_perr[t], 1);
      chk("par_bad_data", h_data[t], 8'h07);
      send(8'h07, 1'b1, 0, k, t);
      chk("par_good", h_perr[t], 0);
`endif
      hold(5);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
